// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the led_pattern_gen slice: channel modes,
// channel control state, config-buffer states and output polarity.
package led_pattern_pkg;

   typedef enum logic [1:0] {
      LED_OFF     = 2'd0,
      LED_ON      = 2'd1,
      LED_BLINK   = 2'd2,
      LED_BREATHE = 2'd3
   } led_mode_e;

   typedef struct packed {
      led_mode_e mode;
      logic      phase;
      logic      dir_down;
   } chan_ctrl_t;

   typedef enum logic {
      CFG_IDLE    = 1'b0,
      CFG_PENDING = 1'b1
   } cfg_state_e;

   function automatic logic led_inactive(input int unsigned active_low);
      return (active_low != 0);
   endfunction

endpackage

// File: rtl/led_pattern_channel.sv
// One LED channel: period counter, blink phase, breathe duty/direction and the
// registered LED drive. LED_PATTERN_GAMMA_EN adds a square-law duty register.
module led_pattern_channel
   import led_pattern_pkg::*;
#(
   parameter int unsigned PERIOD_BITS  = 16,
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned ACTIVE_LOW   = 1,
   parameter int unsigned RESET_PERIOD = 1
) (
   input  logic                   clk_60mhz,
   input  logic                   rst,
   input  logic                   tick,
   input  logic                   load,
   input  logic [1:0]             load_mode,
   input  logic [PERIOD_BITS-1:0] load_period,
   input  logic [PWM_BITS-1:0]    pwm_cnt,
   output logic                   led
);

   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

   chan_ctrl_t             ctrl_q, ctrl_d;
   logic [PERIOD_BITS-1:0] period_q, period_d;
   logic [PERIOD_BITS-1:0] count_q, count_d;
   logic [PERIOD_BITS-1:0] last_count;
   logic [PWM_BITS-1:0]    duty_q, duty_d;
   logic [PWM_BITS-1:0]    duty_eff;
   logic                   on;

   // A stored period of 0 behaves as 1, so the wrap point saturates at 0.
   assign last_count = (period_q == '0) ? '0 : period_q - 1'b1;

   always_comb begin
      ctrl_d   = ctrl_q;
      period_d = period_q;
      count_d  = count_q;
      duty_d   = duty_q;
      if (tick) begin
         if (load) begin
            ctrl_d.mode     = led_mode_e'(load_mode);
            ctrl_d.phase    = 1'b0;
            ctrl_d.dir_down = 1'b0;
            period_d        = load_period;
            count_d         = '0;
            duty_d          = '0;
         end else if (count_q >= last_count) begin
            count_d = '0;
            case (ctrl_q.mode)
               LED_BLINK: ctrl_d.phase = ~ctrl_q.phase;
               LED_BREATHE: begin
                  if (ctrl_q.dir_down) begin
                     duty_d = duty_q - 1'b1;
                     if (duty_q == PWM_BITS'(1)) ctrl_d.dir_down = 1'b0;
                  end else begin
                     duty_d = duty_q + 1'b1;
                     if (duty_q == DUTY_MAX - 1'b1) ctrl_d.dir_down = 1'b1;
                  end
               end
               default: ;
            endcase
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_60mhz) begin
      if (rst) begin
         ctrl_q   <= '{mode: LED_BLINK, phase: 1'b0, dir_down: 1'b0};
         period_q <= PERIOD_BITS'(RESET_PERIOD);
         count_q  <= '0;
         duty_q   <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         period_q <= period_d;
         count_q  <= count_d;
         duty_q   <= duty_d;
      end
   end

`ifdef LED_PATTERN_GAMMA_EN
   logic [2*PWM_BITS-1:0] duty_sq;
   logic [PWM_BITS-1:0]   duty_g_q;

   assign duty_sq = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};

   always_ff @(posedge clk_60mhz) begin
      if (rst) duty_g_q <= '0;
      else     duty_g_q <= duty_sq[2*PWM_BITS-1:PWM_BITS];
   end

   assign duty_eff = duty_g_q;
`else
   assign duty_eff = duty_q;
`endif

   always_comb begin
      on = 1'b0;
      case (ctrl_q.mode)
         LED_OFF:     on = 1'b0;
         LED_ON:      on = 1'b1;
         LED_BLINK:   on = ctrl_q.phase;
         LED_BREATHE: on = (pwm_cnt < duty_eff);
         default:     on = 1'b0;
      endcase
   end

   always_ff @(posedge clk_60mhz) begin
      if (rst) led <= led_inactive(ACTIVE_LOW);
      else     led <= on ^ led_inactive(ACTIVE_LOW);
   end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern driver: shared prescaler tick, free-running PWM
// counter, one-entry config buffer. Build option: LED_PATTERN_GAMMA_EN.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int unsigned CHANNELS    = 6,
   parameter int unsigned PRESCALE    = 60000,
   parameter int unsigned PERIOD_BITS = 16,
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned ACTIVE_LOW  = 1,
   localparam int unsigned CHAN_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                   clk_60mhz,
   input  logic                   rst,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [CHAN_BITS-1:0]   cfg_chan,
   input  logic [1:0]             cfg_mode,
   input  logic [PERIOD_BITS-1:0] cfg_period,
   output logic                   cfg_err,
   output logic                   tick,
   output logic [CHANNELS-1:0]    led
);

   localparam int unsigned PRE_BITS = $clog2(PRESCALE);

   logic [PRE_BITS-1:0]    pre_cnt_q;
   logic [PWM_BITS-1:0]    pwm_cnt_q;

   cfg_state_e             state_q, state_d;
   logic [CHAN_BITS-1:0]   pend_chan_q;
   logic [1:0]             pend_mode_q;
   logic [PERIOD_BITS-1:0] pend_period_q;

   logic                   chan_ok;
   logic                   accept;
   logic                   capture;
   logic                   err_d;
   logic                   wr_valid;
   logic [CHAN_BITS-1:0]   wr_chan;
   logic [1:0]             wr_mode;
   logic [PERIOD_BITS-1:0] wr_period;

   assign tick    = (pre_cnt_q == PRE_BITS'(PRESCALE - 1));
   assign chan_ok = (32'(cfg_chan) < CHANNELS);

   always_ff @(posedge clk_60mhz) begin
      if (rst) begin
         pre_cnt_q <= '0;
         pwm_cnt_q <= '0;
      end else begin
         pre_cnt_q <= tick ? '0 : pre_cnt_q + 1'b1;
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end
   end

   // A write accepted on a tick cycle bypasses the buffer and applies at once.
   always_comb begin
      state_d   = state_q;
      cfg_ready = (state_q == CFG_IDLE);
      accept    = cfg_valid && cfg_ready;
      err_d     = accept && !chan_ok;
      capture   = 1'b0;
      wr_valid  = 1'b0;
      wr_chan   = pend_chan_q;
      wr_mode   = pend_mode_q;
      wr_period = pend_period_q;
      case (state_q)
         CFG_IDLE: begin
            if (accept && chan_ok) begin
               if (tick) begin
                  wr_valid  = 1'b1;
                  wr_chan   = cfg_chan;
                  wr_mode   = cfg_mode;
                  wr_period = cfg_period;
               end else begin
                  capture = 1'b1;
                  state_d = CFG_PENDING;
               end
            end
         end
         CFG_PENDING: begin
            if (tick) begin
               wr_valid = 1'b1;
               state_d  = CFG_IDLE;
            end
         end
         default: state_d = CFG_IDLE;
      endcase
   end

   always_ff @(posedge clk_60mhz) begin
      if (rst) begin
         state_q       <= CFG_IDLE;
         pend_chan_q   <= '0;
         pend_mode_q   <= '0;
         pend_period_q <= '0;
         cfg_err       <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_err <= err_d;
         if (capture) begin
            pend_chan_q   <= cfg_chan;
            pend_mode_q   <= cfg_mode;
            pend_period_q <= cfg_period;
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      logic load;
      assign load = wr_valid && (32'(wr_chan) == c);

      led_pattern_channel #(
         .PERIOD_BITS  (PERIOD_BITS),
         .PWM_BITS     (PWM_BITS),
         .ACTIVE_LOW   (ACTIVE_LOW),
         .RESET_PERIOD (32'd1 << c)
      ) u_chan (
         .clk_60mhz   (clk_60mhz),
         .rst         (rst),
         .tick        (tick),
         .load        (load),
         .load_mode   (wr_mode),
         .load_period (wr_period),
         .pwm_cnt     (pwm_cnt_q),
         .led         (led[c])
      );
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a tick/step-count reference model
// pushes expected outputs each cycle, a negedge monitor pops and compares.
module tb_led_pattern_gen;

   localparam int unsigned CH   = 5;
   localparam int unsigned PS   = 4;
   localparam int unsigned WB   = 4;
   localparam int unsigned DMAX = (1 << WB) - 1;

   logic          clk_60mhz  = 1'b0;
   logic          rst        = 1'b1;
   logic          cfg_valid  = 1'b0;
   logic [2:0]    cfg_chan   = '0;
   logic [1:0]    cfg_mode   = '0;
   logic [15:0]   cfg_period = '0;
   logic          cfg_ready;
   logic          cfg_err;
   logic          tick;
   logic [CH-1:0] led;

   always #5 clk_60mhz = ~clk_60mhz;

   led_pattern_gen #(
      .CHANNELS    (CH),
      .PRESCALE    (PS),
      .PERIOD_BITS (16),
      .PWM_BITS    (WB),
      .ACTIVE_LOW  (1)
   ) dut (
      .clk_60mhz  (clk_60mhz),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_chan   (cfg_chan),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_err    (cfg_err),
      .tick       (tick),
      .led        (led)
   );

   typedef struct packed {
      logic          tick;
      logic          ready;
      logic          err;
      logic [CH-1:0] led;
   } obs_t;

   obs_t exp_q[$];
   obs_t e_obs, a_obs;
   int   checks = 0;
   int   errors = 0;

   // Reference model: each channel is (mode, effective period, ticks since load).
   bit          started = 1'b0;
   int unsigned cyc;
   bit          pend;
   int unsigned p_chan, p_mode, p_per;
   int unsigned m_mode[CH], m_per[CH], m_t[CH], m_gam[CH];
   logic [CH-1:0] m_led;
   logic        m_err;
   bit          m_tk, m_acc, m_ok, m_on, w_ok;
   int unsigned w_chan, w_mode, w_per, m_d, m_dref;

   function automatic int unsigned tri_duty(input int unsigned steps);
      int unsigned pos;
      pos = steps % (2 * DMAX);
      return (pos <= DMAX) ? pos : 2 * DMAX - pos;
   endfunction

   always @(posedge clk_60mhz) begin
      if (rst) begin
         started = 1'b1;
         cyc     = 0;
         pend    = 1'b0;
         m_led   = '1;
         m_err   = 1'b0;
         for (int c = 0; c < CH; c++) begin
            m_mode[c] = 2;
            m_per[c]  = 1 << c;
            m_t[c]    = 0;
            m_gam[c]  = 0;
         end
      end else if (started) begin
         m_tk  = ((cyc % PS) == PS - 1);
         m_acc = cfg_valid && !pend;
         m_ok  = (cfg_chan < CH);
         for (int c = 0; c < CH; c++) begin
            m_d = tri_duty(m_t[c] / m_per[c]);
`ifdef LED_PATTERN_GAMMA_EN
            m_dref   = m_gam[c];
            m_gam[c] = (m_d * m_d) >> WB;
`else
            m_dref = m_d;
`endif
            case (m_mode[c])
               0:       m_on = 1'b0;
               1:       m_on = 1'b1;
               2:       m_on = ((m_t[c] / m_per[c]) % 2) == 1;
               default: m_on = (cyc % (1 << WB)) < m_dref;
            endcase
            m_led[c] = !m_on;
         end
         m_err = m_acc && !m_ok;
         if (m_tk) begin
            w_ok = 1'b0;
            if (pend) begin
               w_ok = 1'b1; w_chan = p_chan; w_mode = p_mode; w_per = p_per;
            end else if (m_acc && m_ok) begin
               w_ok = 1'b1; w_chan = cfg_chan; w_mode = cfg_mode; w_per = cfg_period;
            end
            for (int c = 0; c < CH; c++) begin
               if (w_ok && w_chan == c) begin
                  m_mode[c] = w_mode;
                  m_per[c]  = (w_per == 0) ? 1 : w_per;
                  m_t[c]    = 0;
               end else begin
                  m_t[c]++;
               end
            end
            pend = 1'b0;
         end else if (m_acc && m_ok) begin
            pend   = 1'b1;
            p_chan = cfg_chan;
            p_mode = cfg_mode;
            p_per  = cfg_period;
         end
         cyc++;
      end
      if (started)
         exp_q.push_back({((cyc % PS) == PS - 1), !pend, m_err, m_led});
   end

   always @(negedge clk_60mhz) begin
      if (exp_q.size() > 0) begin
         e_obs = exp_q.pop_front();
         a_obs = {tick, cfg_ready, cfg_err, led};
         checks++;
         if (a_obs !== e_obs) begin
            errors++;
            $display("FAIL outputs t=%0t actual tick=%b ready=%b err=%b led=%b required tick=%b ready=%b err=%b led=%b",
                     $time, a_obs.tick, a_obs.ready, a_obs.err, a_obs.led,
                     e_obs.tick, e_obs.ready, e_obs.err, e_obs.led);
         end
      end
   end

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk_60mhz);
   endtask

   // Entered and left on a negedge; optionally lines the request up with a tick.
   task automatic write(input int unsigned ch, input int unsigned md,
                        input int unsigned per, input bit on_tick);
      int unsigned guard;
      guard = 0;
      if (on_tick)
         while (!(tick && cfg_ready) && guard < 200) begin
            @(negedge clk_60mhz);
            guard++;
         end
      cfg_valid  = 1'b1;
      cfg_chan   = 3'(ch);
      cfg_mode   = 2'(md);
      cfg_period = 16'(per);
      while (!cfg_ready && guard < 200) begin
         @(negedge clk_60mhz);
         guard++;
      end
      checks++;
      if (guard >= 200) begin
         errors++;
         $display("FAIL handshake chan=%0d actual waited=%0d cycles required below 200", ch, guard);
      end
      @(negedge clk_60mhz);
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk_60mhz);
      rst = 1'b0;
   endtask

   initial begin
      int unsigned guard;
      idle(3);
      rst = 1'b0;
      idle(150);

      write(2, 1, 3, 1'b0);
      write(3, 0, 2, 1'b0);
      idle(20);

      write(1, 2, 0, 1'b1);
      idle(20);

      write(0, 3, 1, 1'b0);
      idle(260);

      write(5, 1, 1, 1'b0);
      idle(10);
      write(7, 3, 2, 1'b1);
      idle(10);

      guard = 0;
      while (!tick && guard < 20) begin
         @(negedge clk_60mhz);
         guard++;
      end
      idle(1);
      write(3, 1, 5, 1'b0);
      pulse_reset();
      idle(150);

      for (int i = 0; i < 60; i++) begin
         write($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0));
         idle($urandom_range(0, 30));
         if ($urandom_range(0, 19) == 0) pulse_reset();
      end
      write(0, 3, 1, 1'b0);
      idle(140);

      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
